// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and default sizing for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int DIGITS_DEF = 3;
    localparam int SHOWN_DEF  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between the operand latch, the converter and the display decoder.
interface bin_to_bcd_seq_if
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF
);

    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overload;

    modport master (output start, bin, input busy, done, bcd, overload);
    modport slave  (input start, bin, output busy, done, bcd, overload);

endinterface

// File: rtl/bin_to_bcd_seq_add3.sv
// One BCD digit of the shift-and-add-3 correction: digits of 5 or more get +3 before the shift.
module bcd_add3_digit (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one operand bit per clock; results update only on done.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF,
    parameter int SHOWN  = SHOWN_DEF
) (
    input  logic              clock,
    input  logic              reset,
    bin_to_bcd_seq_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t                     state;
    logic [WIDTH-1:0]           shift_bin;
    logic [4*DIGITS-1:0]        scratch;
    logic [4*DIGITS-1:0]        adjusted;
    logic [4*DIGITS+WIDTH-1:0]  shifted;
    logic [CNT_W-1:0]           cnt;
    logic                       overload_next;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3_digit u_add3 (
            .digit    (scratch[4*g +: 4]),
            .adjusted (adjusted[4*g +: 4])
        );
    end

    // Correction and shift share one cycle; the top digit's carry-out is discarded.
    assign shifted = {adjusted, shift_bin} << 1;

    if (SHOWN >= DIGITS) begin : g_no_ovl
        assign overload_next = 1'b0;
    end else begin : g_ovl
        assign overload_next = |scratch[4*DIGITS-1:4*SHOWN];
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            shift_bin    <= '0;
            scratch      <= '0;
            cnt          <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.bcd      <= '0;
            bus.overload <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // busy is still high during the done pulse, so a start there is dropped.
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    if (bus.start && !bus.busy) begin
                        shift_bin <= bus.bin;
                        scratch   <= '0;
                        cnt       <= CNT_W'(WIDTH);
                        bus.busy  <= 1'b1;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    scratch   <= shifted[4*DIGITS+WIDTH-1:WIDTH];
                    shift_bin <= shifted[WIDTH-1:0];
                    cnt       <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bus.bcd      <= scratch;
                    bus.overload <= overload_next;
                    bus.done     <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
